// File: rtl/fp_normalize_round.sv
// rtl/fp_normalize_round.sv - binary32 normalize, round-to-nearest-even and pack stage
//
// Two-stage valid/ready pipeline placed after the add/sub mantissa datapath.
// S1 normalizes the incoming extended mantissa (carry right-shift or
// leading-zero left-shift) and registers it; S2 rounds, packs and holds the
// result registers that drive the outputs.
//
// Ports:
//   CLK, nRST             clock, synchronous active-low reset
//   in_valid/in_ready     upstream handshake
//   in_sign, in_exp       result sign, biased exponent of the larger operand
//   in_mant[27:0]         {carry, hidden, frac[22:0], guard, round, sticky}
//   out_valid/out_ready   downstream handshake
//   result                packed binary32
//   overflow, underflow   saturated to infinity / flushed to signed zero
//   inexact               nonzero bits discarded, or overflow/underflow
module fp_normalize_round (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [27:0] in_mant,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        inexact
);

    // Leading zeros of a 27-bit vector; an all-zero input never reaches the
    // shifter because the zero case is handled separately.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       done;
        n    = 5'd0;
        done = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!done) begin
                if (v[i]) done = 1'b1;
                else      n    = n + 5'd1;
            end
        end
        return n;
    endfunction

    // Pipeline control: each stage advances when it is empty or the stage
    // below it is moving, so two items can be held without a bubble.
    logic s1_valid;
    logic s2_valid;
    logic s2_adv;
    logic s1_adv;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    // ---------------- S1: normalization ----------------
    logic [4:0]        lz;
    logic [26:0]       norm_mant;
    logic signed [9:0] norm_exp;
    logic              in_zero;
    logic              in_uf;

    always_comb begin
        lz        = lzc27(in_mant[26:0]);
        norm_mant = '0;
        norm_exp  = '0;
        if (in_mant[27]) begin
            // The bit shifted out of the carry position folds into sticky.
            norm_mant = {in_mant[27:2], in_mant[1] | in_mant[0]};
            norm_exp  = $signed({2'b00, in_exp}) + 10'sd1;
        end else begin
            norm_mant = in_mant[26:0] << lz;
            norm_exp  = $signed({2'b00, in_exp}) - $signed({5'd0, lz});
        end
        in_zero = (in_mant == 28'd0);
        // A zero biased exponent marks a subnormal-range source; this stage
        // does not emit subnormals, so it flushes as well.
        in_uf   = !in_zero && ((norm_exp <= 10'sd0) || (in_exp == 8'd0));
    end

    logic              s1_sign;
    logic signed [9:0] s1_exp;
    logic [26:0]       s1_mant;
    logic              s1_zero;
    logic              s1_uf;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
        end
    end

    always_ff @(posedge CLK) begin
        if (s1_adv && in_valid) begin
            s1_sign <= in_sign;
            s1_exp  <= norm_exp;
            s1_mant <= norm_mant;
            s1_zero <= in_zero;
            s1_uf   <= in_uf;
        end
    end

    // ---------------- S2: round and pack ----------------
    logic              lsb_bit;
    logic              guard_bit;
    logic              round_bit;
    logic              sticky_bit;
    logic              round_up;
    logic [24:0]       sig_rnd;
    logic signed [9:0] exp_rnd;
    logic [22:0]       frac_rnd;
    logic [31:0]       pack_result;
    logic              pack_ovf;
    logic              pack_uf;
    logic              pack_inx;

    always_comb begin
        lsb_bit    = s1_mant[3];
        guard_bit  = s1_mant[2];
        round_bit  = s1_mant[1];
        sticky_bit = s1_mant[0];
        round_up   = guard_bit && (round_bit || sticky_bit || lsb_bit);
        sig_rnd    = {1'b0, s1_mant[26:3]} + {24'd0, round_up};
        // Carry out of the 24-bit significand: mantissa becomes 1.0, exponent bumps.
        exp_rnd    = sig_rnd[24] ? (s1_exp + 10'sd1) : s1_exp;
        frac_rnd   = sig_rnd[24] ? 23'd0 : sig_rnd[22:0];

        pack_result = 32'd0;
        pack_ovf    = 1'b0;
        pack_uf     = 1'b0;
        pack_inx    = 1'b0;
        if (s1_zero) begin
            pack_result = 32'd0;
        end else if (s1_uf) begin
            pack_result = {s1_sign, 31'd0};
            pack_uf     = 1'b1;
            pack_inx    = 1'b1;
        end else if (exp_rnd >= 10'sd255) begin
            pack_result = {s1_sign, 8'hFF, 23'd0};
            pack_ovf    = 1'b1;
            pack_inx    = 1'b1;
        end else begin
            pack_result = {s1_sign, exp_rnd[7:0], frac_rnd};
            pack_inx    = guard_bit || round_bit || sticky_bit;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            s2_valid  <= 1'b0;
            result    <= 32'd0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                result    <= pack_result;
                overflow  <= pack_ovf;
                underflow <= pack_uf;
                inexact   <= pack_inx;
            end
        end
    end

endmodule
